// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: round-robin fetch/data arbiter onto a four-phase ren/wen/ack channel with timeout retry
module mem_req_arbiter #(
  parameter int TIMEOUT = 256,
  parameter int RETRIES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  output logic        if_err,
  input  logic        d_ren,
  input  logic        d_wen,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        d_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_i,
  output logic        mem_ren,
  output logic        mem_wen,
  input  logic        mem_ack,
  input  logic [31:0] mem_data_o,
  output logic        busy
);
  localparam int TW = $clog2(TIMEOUT);
  localparam int RW = (RETRIES < 1) ? 1 : $clog2(RETRIES + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, RELEASE, DONE} state_t;
  state_t state, state_n;
  logic [TW-1:0] tcnt;
  logic [RW-1:0] rcnt;
  logic [31:0] rbuf;
  logic retry, err, port, op_wr, last_d;
  logic d_c, gnt_d, tmo, op_wr_n;
  assign d_c = d_ren | d_wen;
  assign gnt_d = d_c & (!if_req | !last_d);
  assign tmo = tcnt == TW'(TIMEOUT - 1);
  assign op_wr_n = (state == IDLE) ? gnt_d & d_wen : op_wr;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = (if_req | d_c) ? ISSUE : IDLE;
      ISSUE:   state_n = (mem_ack | tmo) ? RELEASE : ISSUE;
      RELEASE: state_n = mem_ack ? RELEASE : (retry ? ISSUE : DONE);
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      {if_rdata, if_done, if_err, d_rdata, d_done, d_err} <= '0;
      {mem_addr, mem_data_i, mem_ren, mem_wen, busy} <= '0;
      {tcnt, rcnt, rbuf, retry, err, port, op_wr} <= '0;
      last_d <= 1'b1;
    end else begin
      state <= state_n;
      busy <= state_n != IDLE;
      mem_ren <= state_n == ISSUE && !op_wr_n;
      mem_wen <= state_n == ISSUE && op_wr_n;
      if_done <= state_n == DONE && !port;
      d_done <= state_n == DONE && port;
      if_err <= state_n == DONE && !port && err;
      d_err <= state_n == DONE && port && err;
      if (state == RELEASE && state_n == DONE && !op_wr) begin
        if (port) d_rdata <= rbuf;
        else if_rdata <= rbuf;
      end
      case (state)
        IDLE: if (if_req | d_c) begin
          port <= gnt_d;
          last_d <= gnt_d;
          op_wr <= gnt_d & d_wen;
          mem_addr <= gnt_d ? d_addr : if_addr;
          mem_data_i <= gnt_d ? d_wdata : '0;
          {tcnt, rcnt, retry, err} <= '0;
        end
        ISSUE: if (mem_ack) begin
          rbuf <= mem_data_o;
          err <= 1'b0;
        end else if (tmo) begin
          if (rcnt < RW'(RETRIES)) begin
            rcnt <= rcnt + 1'b1;
            retry <= 1'b1;
          end else begin
            err <= 1'b1;
            rbuf <= '0;
          end
        end else tcnt <= tcnt + 1'b1;
        RELEASE: if (!mem_ack && retry) begin
          tcnt <= '0;
          retry <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule
